wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: registers ALU results or load data into the register-file write port.
// Optional load-timeout watchdog is enabled by defining WB_TIMEOUT_EN.
module wb_stage #(
  parameter int WIDTH   = 32,
  parameter int SIZE    = 16,
  parameter int TIMEOUT = 255,
  localparam int DW     = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_wb_en,
  input  logic             in_mem_r_en,
  input  logic [DW-1:0]    in_dest,
  input  logic [WIDTH-1:0] in_alu_res,
  input  logic             rdata_valid,
  input  logic [WIDTH-1:0] rdata,
  output logic             WB_WB_EN,
  output logic [DW-1:0]    Dest_wb,
  output logic [WIDTH-1:0] WB_Value,
  output logic             pend_valid,
  output logic [DW-1:0]    pend_dest,
  output logic             rdata_err,
  output logic             timeout_err
);

  // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, so the MEM stage may hold in_valid across cycles.

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } state_t;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_stage: TIMEOUT must be in 1..255");
  end

  state_t           state, state_d;
  logic             cap_wb_en;
  logic [DW-1:0]    cap_dest;
  logic             wb_en_q;
  logic [DW-1:0]    dest_q;
  logic [WIDTH-1:0] value_q;
  logic             rdata_err_q;

`ifdef WB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  logic [7:0] to_cnt;
  logic       timeout_err_q;
  logic       to_hit;

  // rdata_valid in the limit cycle still completes the load normally
  assign to_hit      = (state == WAIT_DATA) && !rdata_valid && (to_cnt == TO_LIM);
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign in_ready   = (state == IDLE);
  assign pend_valid = (state == WAIT_DATA) && cap_wb_en;
  assign pend_dest  = cap_dest;
  assign WB_WB_EN   = wb_en_q;
  assign Dest_wb    = dest_q;
  assign WB_Value   = value_q;
  assign rdata_err  = rdata_err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (in_valid && in_mem_r_en) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (rdata_valid) state_d = IDLE;
`ifdef WB_TIMEOUT_EN
        else if (to_hit) state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port: the enable is a one-cycle pulse, address/data hold between writes
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q     <= 1'b0;
      dest_q      <= '0;
      value_q     <= '0;
      cap_wb_en   <= 1'b0;
      cap_dest    <= '0;
      rdata_err_q <= 1'b0;
    end else begin
      wb_en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_mem_r_en) begin
              cap_wb_en <= in_wb_en;
              cap_dest  <= in_dest;
            end else if (in_wb_en) begin
              wb_en_q <= 1'b1;
              dest_q  <= in_dest;
              value_q <= in_alu_res;
            end
          end
          if (rdata_valid) rdata_err_q <= 1'b1;
        end
        WAIT_DATA: begin
          if (rdata_valid && cap_wb_en) begin
            wb_en_q <= 1'b1;
            dest_q  <= cap_dest;
            value_q <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt        <= '0;
      timeout_err_q <= 1'b0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else begin
      if (!rdata_valid && to_cnt != TO_LIM) to_cnt <= to_cnt + 8'd1;
      if (to_hit) timeout_err_q <= 1'b1;
    end
  end
`endif

endmodule
